// File: rtl/irq_ctrl_if.sv
// Register bus between the CPU address decoder and the interrupt controller.
// The master drives the select, write and address lines; the slave returns read data.
interface irq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [1:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (
    output cs,
    output wen,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  wen,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// 32-source interrupt controller with per-source edge/level mode, enable mask,
// fixed lowest-index priority, and a single non-nesting in-service slot.
module irq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  irq_ctrl_if.slave         bus,
  input  logic [31:0]       irq_in,
  input  logic              irq_ack,
  output logic              irq,
  output logic [4:0]        irq_vec
);

  localparam logic [1:0] AddrPend = 2'd0;
  localparam logic [1:0] AddrEna  = 2'd1;
  localparam logic [1:0] AddrMode = 2'd2;
  localparam logic [1:0] AddrVec  = 2'd3;

  logic [31:0] pend_q, pend_d;
  logic [31:0] ena_q, ena_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] irq_prev_q;
  logic [4:0]  active_vec_q, active_vec_d;
  logic        in_service_q, in_service_d;

  logic        wr;
  logic        ack_fire;
  logic [31:0] eligible;
  logic [31:0] rise;
  logic [31:0] clr;

  assign wr       = bus.cs & bus.wen;
  assign eligible = pend_q & ena_q;
  assign rise     = irq_in & ~irq_prev_q;
  assign irq      = (|eligible) & ~in_service_q;
  assign ack_fire = irq_ack & irq;

  always_comb begin
    irq_vec = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (eligible[i]) irq_vec = 5'(i);
    end
  end

  always_comb begin
    ena_d        = ena_q;
    mode_d       = mode_q;
    in_service_d = in_service_q;
    active_vec_d = active_vec_q;
    clr          = 32'd0;

    if (wr && bus.addr == AddrEna)  ena_d  = bus.din[31:0];
    if (wr && bus.addr == AddrMode) mode_d = bus.din[31:0];
    if (wr && bus.addr == AddrPend) clr    = bus.din[31:0];
    if (wr && bus.addr == AddrVec)  in_service_d = 1'b0;

    // Acknowledge takes priority over a same-cycle EOI.
    if (ack_fire) begin
      in_service_d = 1'b1;
      active_vec_d = irq_vec;
      clr          = clr | (32'd1 << irq_vec);
    end

    // Edge bits: a new rise beats any clear. Level bits track irq_in, except that a
    // bit switching to edge mode starts clear so a steady-high line never pends.
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & irq_in & ~mode_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 32'd0;
      ena_q        <= 32'd0;
      mode_q       <= 32'd0;
      irq_prev_q   <= 32'd0;
      active_vec_q <= 5'd0;
      in_service_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      ena_q        <= ena_d;
      mode_q       <= mode_d;
      irq_prev_q   <= irq_in;
      active_vec_q <= active_vec_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    bus.dout = '0;
    if (bus.cs && !bus.wen) begin
      unique case (bus.addr)
        AddrPend: bus.dout = pend_q;
        AddrEna:  bus.dout = ena_q;
        AddrMode: bus.dout = mode_q;
        AddrVec:  bus.dout = {in_service_q, 26'd0, active_vec_q};
        default:  bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued as stimulus is applied
// and popped against DUT outputs sampled one time unit after each rising edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] irq_in;
  logic        irq_ack;
  logic        irq;
  logic [4:0]  irq_vec;

  irq_ctrl_if #(.WIDTH(32)) bus ();

  irq_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_ack (irq_ack),
    .irq     (irq),
    .irq_vec (irq_vec)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got %08h expected none", got);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.cs   = 1'b1;
    bus.wen  = 1'b1;
    bus.addr = a;
    bus.din  = d;
    cycle();
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.din  = 32'd0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
    logic [31:0] d;
    sb_push(tag, v);
    bus.cs   = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = a;
    @(negedge clk);
    d = bus.dout;
    cycle();
    bus.cs = 1'b0;
    sb_pop(d);
  endtask

  task automatic expect_irq(input string tag, input logic e_irq, input logic [4:0] e_vec);
    sb_push({tag, "_irq"}, {31'd0, e_irq});
    sb_push({tag, "_vec"}, {27'd0, e_vec});
    sb_pop({31'd0, irq});
    sb_pop({27'd0, irq_vec});
  endtask

  initial begin
    reset    = 1'b1;
    irq_in   = 32'd0;
    irq_ack  = 1'b0;
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.addr = 2'd0;
    bus.din  = 32'd0;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    expect_irq("rst", 1'b0, 5'd0);
    sb_push("rst_dout_idle", 32'd0);
    sb_pop(bus.dout);
    expect_reg("rst_pend", 2'd0, 32'd0);
    expect_reg("rst_ena",  2'd1, 32'd0);
    expect_reg("rst_mode", 2'd2, 32'd0);
    expect_reg("rst_vec",  2'd3, 32'd0);

    // Level source 0
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'd1);
    irq_in[0] = 1'b1;
    expect_irq("lvl_pre", 1'b0, 5'd0);
    cycle();
    expect_irq("lvl_on", 1'b1, 5'd0);
    expect_reg("lvl_pend", 2'd0, 32'h1);
    irq_in[0] = 1'b0;
    cycle();
    expect_irq("lvl_off", 1'b0, 5'd0);
    expect_reg("lvl_pend_off", 2'd0, 32'h0);

    // Edge source 3 with acknowledge and EOI
    bus_write(2'd2, 32'h8);
    bus_write(2'd1, 32'h8);
    irq_in[3] = 1'b1;
    cycle();
    irq_in[3] = 1'b0;
    expect_irq("edge_on", 1'b1, 5'd3);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    expect_irq("edge_ack", 1'b0, 5'd0);
    expect_reg("edge_vec", 2'd3, 32'h8000_0003);
    expect_reg("edge_pend", 2'd0, 32'h0);
    bus_write(2'd3, 32'd0);
    expect_reg("edge_eoi_vec", 2'd3, 32'h0000_0003);

    // Priority between edge sources 5 and 2
    bus_write(2'd2, 32'h24);
    bus_write(2'd1, 32'h24);
    irq_in = 32'h24;
    cycle();
    irq_in = 32'h0;
    expect_irq("prio_first", 1'b1, 5'd2);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    expect_irq("prio_insvc", 1'b0, 5'd5);
    expect_reg("prio_vec", 2'd3, 32'h8000_0002);
    bus_write(2'd3, 32'd0);
    expect_irq("prio_second", 1'b1, 5'd5);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    bus_write(2'd3, 32'd0);
    expect_irq("prio_done", 1'b0, 5'd0);
    expect_reg("prio_vec2", 2'd3, 32'h0000_0005);

    // Edge on 7 colliding with a PEND clear of the same bit: set wins
    bus_write(2'd2, 32'h80);
    bus_write(2'd1, 32'h0);
    irq_in[7] = 1'b1;
    bus_write(2'd0, 32'h80);
    irq_in[7] = 1'b0;
    expect_reg("coll_pend", 2'd0, 32'h80);
    bus_write(2'd0, 32'h80);
    expect_reg("coll_clr", 2'd0, 32'h0);

    // Masked edge source 4 stays pending and reappears when enabled
    bus_write(2'd2, 32'h10);
    irq_in[4] = 1'b1;
    cycle();
    irq_in[4] = 1'b0;
    expect_irq("mask_off", 1'b0, 5'd0);
    expect_reg("mask_pend", 2'd0, 32'h10);
    bus_write(2'd1, 32'h10);
    expect_irq("mask_on", 1'b1, 5'd4);

    // Reset while in service with a pending bit; reset beats write/ack/edge
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    irq_in[4] = 1'b1;
    cycle();
    irq_in[4] = 1'b0;
    expect_irq("svc_block", 1'b0, 5'd4);
    expect_reg("svc_pend", 2'd0, 32'h10);
    expect_reg("svc_vec", 2'd3, 32'h8000_0004);
    reset    = 1'b1;
    irq_ack  = 1'b1;
    irq_in   = 32'h200;
    bus_write(2'd1, 32'hffff_ffff);
    reset    = 1'b0;
    irq_ack  = 1'b0;
    irq_in   = 32'h0;
    expect_irq("rst2", 1'b0, 5'd0);
    expect_reg("rst2_pend", 2'd0, 32'd0);
    expect_reg("rst2_ena",  2'd1, 32'd0);
    expect_reg("rst2_mode", 2'd2, 32'd0);
    expect_reg("rst2_vec",  2'd3, 32'd0);

    // Stray acknowledge with irq low is ignored
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    expect_reg("stray_ack_vec", 2'd3, 32'd0);

    // Line held high through reset must not pend in edge mode until it re-rises
    reset     = 1'b1;
    irq_in[6] = 1'b1;
    cycle();
    reset = 1'b0;
    bus_write(2'd2, 32'h40);
    bus_write(2'd1, 32'h40);
    cycle();
    expect_irq("hold_none", 1'b0, 5'd0);
    expect_reg("hold_pend", 2'd0, 32'd0);
    irq_in[6] = 1'b0;
    cycle();
    irq_in[6] = 1'b1;
    cycle();
    expect_irq("hold_rerise", 1'b1, 5'd6);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
